// File: rtl/nsf_sched_pkg.sv
// Shared definitions for the NSF play-routine scheduler: register map,
// FSM state encoding and control/status bit positions.
package nsf_sched_pkg;

  localparam logic [15:0] REG_PER_LO = 16'h42F0;
  localparam logic [15:0] REG_PER_HI = 16'h42F1;
  localparam logic [15:0] REG_CTRL   = 16'h42F2;
  localparam logic [15:0] REG_STATUS = 16'h42F3;
  localparam logic [15:0] REG_ACK    = 16'h42F4;
  localparam logic [15:0] REG_OVR    = 16'h42F5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int CTRL_RUN_EN  = 0;
  localparam int CTRL_INIT_GO = 1;
  localparam int CTRL_IRQ_EN  = 3;

endpackage

// File: rtl/nsf_tick_gen.sv
// Microsecond prescaler plus period down-counter producing the PLAY tick.
// While disabled the counter tracks the period register so RUN entry starts a fresh interval.
module nsf_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] period,
  output logic        play_tick
);

  localparam logic [7:0] US_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  us_cnt_r;
  logic [15:0] per_cnt_r;
  logic        us_tick_s;

  assign us_tick_s = en & (us_cnt_r == US_LAST);
  assign play_tick = us_tick_s & (per_cnt_r == 16'd1);

  // Prescaler: one us_tick every CLK_DIV cycles, parked at zero outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt_r <= 8'd0;
    end else if (!en || us_tick_s) begin
      us_cnt_r <= 8'd0;
    end else begin
      us_cnt_r <= us_cnt_r + 8'd1;
    end
  end

  // Period counter: load on entry, reload on play_tick; a zero count holds forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_r <= 16'd0;
    end else if (!en || play_tick) begin
      per_cnt_r <= period;
    end else if (us_tick_s && (per_cnt_r != 16'd0)) begin
      per_cnt_r <= per_cnt_r - 16'd1;
    end else begin
      per_cnt_r <= per_cnt_r;
    end
  end

endmodule

// File: rtl/nsf_play_sched.sv
// NSF play scheduler top: register file, IDLE/INIT/RUN sequencer and the
// pending/overrun handshake that drives player ROM mapping and the play IRQ.
module nsf_play_sched
  import nsf_sched_pkg::*;
#(
  parameter int          CLK_DIV    = 50,
  parameter logic [15:0] PERIOD_RST = 16'h40FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_rd,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  output logic        player_map,
  output logic        irq,
  output logic [1:0]  state_o
);

  state_t      state_r, state_d;
  logic [15:0] period_r;
  logic        run_en_r, irq_en_r;
  logic        pending_r, pending_d;
  logic [7:0]  ovr_cnt_r;
  logic        ovr_sticky_r;
  logic        ovr_hit_s;

  logic wr_ctrl_s, ack_s, wr_ovr_s, go_s, stop_s;
  logic tick_en_s, play_tick_s;

  assign wr_ctrl_s = bus_we & (bus_addr == REG_CTRL);
  assign ack_s     = bus_we & (bus_addr == REG_ACK);
  assign wr_ovr_s  = bus_we & (bus_addr == REG_OVR);
  assign go_s      = wr_ctrl_s & bus_din[CTRL_RUN_EN] & bus_din[CTRL_INIT_GO];
  assign stop_s    = wr_ctrl_s & ~bus_din[CTRL_RUN_EN];

  // run_en is always set in RUN; gating on it keeps the tick source tied to the stored enable
  assign tick_en_s = (state_r == RUN) & run_en_r;

  nsf_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (tick_en_s),
    .period    (period_r),
    .play_tick (play_tick_s)
  );

  // Sequencer next state; a run_en=0 write wins from any state
  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) state_d = INIT;
        else      state_d = IDLE;
      end
      INIT: begin
        if (stop_s)     state_d = IDLE;
        else if (ack_s) state_d = RUN;
        else            state_d = INIT;
      end
      RUN: begin
        if (stop_s)    state_d = IDLE;
        else if (go_s) state_d = INIT;
        else           state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending handshake: a tick beats a simultaneous ack, leaving RUN drops the request
  always_comb begin
    pending_d = 1'b0;
    ovr_hit_s = 1'b0;
    if ((state_r == RUN) && (state_d == RUN)) begin
      if (play_tick_s) begin
        pending_d = 1'b1;
        ovr_hit_s = pending_r & ~ack_s;
      end else if (ack_s) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_r;
      end
    end else begin
      pending_d = 1'b0;
    end
  end

  // State and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_d;
      pending_r <= pending_d;
    end
  end

  // CPU-writable configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r <= PERIOD_RST;
      run_en_r <= 1'b0;
      irq_en_r <= 1'b0;
    end else if (bus_we) begin
      if (bus_addr == REG_PER_LO) period_r[7:0]  <= bus_din;
      if (bus_addr == REG_PER_HI) period_r[15:8] <= bus_din;
      if (bus_addr == REG_CTRL) begin
        run_en_r <= bus_din[CTRL_RUN_EN];
        irq_en_r <= bus_din[CTRL_IRQ_EN];
      end
    end
  end

  // Overrun bookkeeping; a CPU clear takes priority over a same-cycle overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt_r    <= 8'd0;
      ovr_sticky_r <= 1'b0;
    end else if (wr_ovr_s) begin
      ovr_cnt_r    <= 8'd0;
      ovr_sticky_r <= 1'b0;
    end else if (ovr_hit_s) begin
      ovr_sticky_r <= 1'b1;
      if (ovr_cnt_r != 8'hFF) ovr_cnt_r <= ovr_cnt_r + 8'd1;
    end
  end

  // Combinational read mux; the bus floats high when not selected
  always_comb begin
    bus_oe   = 1'b0;
    bus_dout = 8'hFF;
    if (bus_rd && (bus_addr == REG_STATUS)) begin
      bus_oe   = 1'b1;
      bus_dout = {5'd0, ovr_sticky_r, (state_r == INIT), pending_r};
    end else if (bus_rd && (bus_addr == REG_OVR)) begin
      bus_oe   = 1'b1;
      bus_dout = ovr_cnt_r;
    end else begin
      bus_oe   = 1'b0;
      bus_dout = 8'hFF;
    end
  end

  assign player_map = (state_r != RUN) | pending_r;
  assign irq        = irq_en_r & pending_r & (state_r == RUN);
  assign state_o    = state_r;

endmodule
